sn7476: RTL and testbench
=========================

SN7476 -- requirements
Module: sn7476

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, ports named clk and rst.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  system sampling clock, rising-edge
- rst  in  1  async active-high reset
- p1   in  1  FF1 clock pulse (1CLK)
- p2   in  1  FF1 preset, active-low (1PRE_n)
- p3   in  1  FF1 clear, active-low (1CLR_n)
- p4   in  1  FF1 J
- p5   in  1  VCC; ignored
- p6   in  1  FF2 clock pulse (2CLK)
- p7   in  1  FF2 preset, active-low
- p8   in  1  FF2 clear, active-low
- p9   in  1  FF2 J
- p10  out 1  FF2 Q_n
- p11  out 1  FF2 Q
- p12  in  1  FF2 K
- p13  in  1  GND; ignored
- p14  out 1  FF1 Q_n
- p15  out 1  FF1 Q
- p16  in  1  FF1 K

Function
REQ-003 The block SHALL implement two independent, identical JK master-slave flip-flops: FF1 (p1,p2,p3,p4,p16 -> p15,p14) and FF2 (p6,p7,p8,p9,p12 -> p11,p10).
REQ-004 Each FF SHALL hold a master bit M, a slave bit S and a registered copy of its pin clock (clk_d); all are updated on rising clk.
REQ-005 Q SHALL equal S and Q_n SHALL equal ~S, except when PRE_n=0 and CLR_n=0 together, where Q=1 and Q_n=1 combinationally.
REQ-006 PRE_n=0 with CLR_n=1 SHALL force Q=1/Q_n=0 combinationally, and M=S=1 at the next clk edge.
REQ-007 CLR_n=0 SHALL force Q=0/Q_n=1 combinationally, and M=S=0 at the next clk edge; CLR_n dominates the stored state when both are low.
REQ-008 While a preset or clear is active, the pin clock SHALL be ignored.
REQ-009 While the pin clock is sampled high, M SHALL capture per edge: J=1 and S=0 -> M=1; K=1 and S=1 -> M=0; otherwise M holds. This gives ones-catching: a J or K pulse of one clk cycle while the pin clock is high is retained.
REQ-010 While the pin clock is sampled low, M SHALL be loaded with S.
REQ-011 On a detected falling pin clock (clk_d=1, pin=0), S SHALL load M; Q/Q_n SHALL change one clk cycle after the falling pin clock is sampled.
REQ-012 Resulting truth table at the falling pin clock, with J/K stable while high: J=0,K=0 hold; J=1,K=0 Q=1; J=0,K=1 Q=0; J=1,K=1 toggle.
REQ-013 A rising pin clock SHALL never change Q.

Reset
REQ-014 rst=1 SHALL asynchronously set M=0, S=0 and clk_d=0 for both FFs; Q=0 and Q_n=1 unless a preset is active.
REQ-015 Reset release SHALL need no pin activity; the first falling pin clock is detected only after a sampled high.

Configuration
REQ-016 With macro SN7476_ONES_CATCH_EN defined, the block SHALL implement the ones-catching master behavior of REQ-009.
REQ-017 Without SN7476_ONES_CATCH_EN, the block SHALL be negative-edge-triggered instead: J/K are sampled only in the clk cycle that detects the falling pin clock, and applied per REQ-012 from the current S; no master state is kept.

Structure
REQ-018 A shared package sn7476_pkg SHALL hold the pin-role constants and a JK-mode enum (HOLD, RESET, SET, TOGGLE).
REQ-019 The block SHALL be built from one sub-module, jk_ms_ff, instantiated twice; sn7476 does only pin mapping.

Verification
REQ-020 Async control: p2=0,p3=1 -> p15=1,p14=0; then p2=1,p3=0 -> p15=0; then p2=1,p3=1 -> p15 stays 0. Repeat on p7/p8 -> p11.
REQ-021 JK table, FF1: (p4,p16)=(0,1) pulse -> p15=0,p14=1; (1,0) -> 1/0; (0,0) -> 1/0 hold; (1,1) -> 0/1 toggle. Repeat on FF2 with p9/p12 -> p11/p10.
REQ-022 Ones-catch (macro defined): Q=1, J=K=0, p1 high, p16 pulses 1 then 0 while p1 high, p1 falls -> p15=0; without the macro, p15 stays 1.
REQ-023 Both-low: p2=0,p3=0 -> p15=1 and p14=1; release to 1,1 -> p15=0, p14=1.
REQ-024 rst asserted mid-pulse with Q=1 -> p15=0 immediately; the following falling p1 with J=K=0 keeps p15=0.

Source files
------------

// File: rtl/sn7476_pkg.sv
// Shared definitions for the SN7476 dual JK flip-flop: pin numbers, JK modes
// and the J/K next-state helper.
package sn7476_pkg;

  localparam int PIN_1CLK   = 1;
  localparam int PIN_1PRE_N = 2;
  localparam int PIN_1CLR_N = 3;
  localparam int PIN_1J     = 4;
  localparam int PIN_VCC    = 5;
  localparam int PIN_2CLK   = 6;
  localparam int PIN_2PRE_N = 7;
  localparam int PIN_2CLR_N = 8;
  localparam int PIN_2J     = 9;
  localparam int PIN_2Q_N   = 10;
  localparam int PIN_2Q     = 11;
  localparam int PIN_2K     = 12;
  localparam int PIN_GND    = 13;
  localparam int PIN_1Q_N   = 14;
  localparam int PIN_1Q     = 15;
  localparam int PIN_1K     = 16;

  // Encoded as {J,K}.
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_mode_e;

  function automatic logic jk_next(input logic s, input logic j, input logic k);
    jk_mode_e mode;
    logic     nxt;
    mode = jk_mode_e'({j, k});
    case (mode)
      RESET:   nxt = 1'b0;
      SET:     nxt = 1'b1;
      TOGGLE:  nxt = ~s;
      default: nxt = s;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sn7476_jk_ms_ff.sv
// One JK master-slave flip-flop with async-style preset/clear, oversampled on clk.
// SN7476_ONES_CATCH_EN selects the ones-catching master; otherwise negative-edge JK.
module jk_ms_ff
  import sn7476_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clk_pin,
  input  logic i_pre_n,
  input  logic i_clr_n,
  input  logic i_j,
  input  logic i_k,
  output logic o_q,
  output logic o_q_n
);

  logic r_m;
  logic r_s;
  logic r_clk_d;
  logic w_fall;

  assign w_fall = r_clk_d & ~i_clk_pin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m     <= 1'b0;
      r_s     <= 1'b0;
      r_clk_d <= 1'b0;
    end else begin
      r_clk_d <= i_clk_pin;
      if (!i_clr_n) begin
        r_m <= 1'b0;
        r_s <= 1'b0;
      end else if (!i_pre_n) begin
        r_m <= 1'b1;
        r_s <= 1'b1;
      end else begin
`ifdef SN7476_ONES_CATCH_EN
        if (i_clk_pin) begin
          // Master latches the first J/K pulse seen while the pin clock is high.
          if (i_j && !r_s)
            r_m <= 1'b1;
          else if (i_k && r_s)
            r_m <= 1'b0;
        end else begin
          r_m <= r_s;
        end
        if (w_fall)
          r_s <= r_m;
`else
        r_m <= r_s;
        if (w_fall)
          r_s <= jk_next(r_s, i_j, i_k);
`endif
      end
    end
  end

  // Preset/clear override the outputs without waiting for clk; both low drives both high.
  always_comb begin
    o_q   = r_s;
    o_q_n = ~r_s;
    if (!i_pre_n && !i_clr_n) begin
      o_q   = 1'b1;
      o_q_n = 1'b1;
    end else if (!i_clr_n) begin
      o_q   = 1'b0;
      o_q_n = 1'b1;
    end else if (!i_pre_n) begin
      o_q   = 1'b1;
      o_q_n = 1'b0;
    end
  end

endmodule

// File: rtl/sn7476.sv
// SN7476 dual JK master-slave flip-flop: pin mapping onto two jk_ms_ff instances.
// Optional build macro: SN7476_ONES_CATCH_EN (ones-catching master).
module sn7476
  import sn7476_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic p1,
  input  logic p2,
  input  logic p3,
  input  logic p4,
  input  logic p5,
  input  logic p6,
  input  logic p7,
  input  logic p8,
  input  logic p9,
  output logic p10,
  output logic p11,
  input  logic p12,
  input  logic p13,
  output logic p14,
  output logic p15,
  input  logic p16
);

  logic [16:1] w_pin;
  logic        w_unused;

  assign w_pin[PIN_1CLK]   = p1;
  assign w_pin[PIN_1PRE_N] = p2;
  assign w_pin[PIN_1CLR_N] = p3;
  assign w_pin[PIN_1J]     = p4;
  assign w_pin[PIN_VCC]    = p5;
  assign w_pin[PIN_2CLK]   = p6;
  assign w_pin[PIN_2PRE_N] = p7;
  assign w_pin[PIN_2CLR_N] = p8;
  assign w_pin[PIN_2J]     = p9;
  assign w_pin[PIN_2K]     = p12;
  assign w_pin[PIN_GND]    = p13;
  assign w_pin[PIN_1K]     = p16;

  // Supply pins carry no logic.
  assign w_unused = w_pin[PIN_VCC] ^ w_pin[PIN_GND];

  jk_ms_ff u_ff1 (
    .clk       (clk),
    .rst       (rst),
    .i_clk_pin (w_pin[PIN_1CLK]),
    .i_pre_n   (w_pin[PIN_1PRE_N]),
    .i_clr_n   (w_pin[PIN_1CLR_N]),
    .i_j       (w_pin[PIN_1J]),
    .i_k       (w_pin[PIN_1K]),
    .o_q       (w_pin[PIN_1Q]),
    .o_q_n     (w_pin[PIN_1Q_N])
  );

  jk_ms_ff u_ff2 (
    .clk       (clk),
    .rst       (rst),
    .i_clk_pin (w_pin[PIN_2CLK]),
    .i_pre_n   (w_pin[PIN_2PRE_N]),
    .i_clr_n   (w_pin[PIN_2CLR_N]),
    .i_j       (w_pin[PIN_2J]),
    .i_k       (w_pin[PIN_2K]),
    .o_q       (w_pin[PIN_2Q]),
    .o_q_n     (w_pin[PIN_2Q_N])
  );

  assign p15 = w_pin[PIN_1Q];
  assign p14 = w_pin[PIN_1Q_N];
  assign p11 = w_pin[PIN_2Q];
  assign p10 = w_pin[PIN_2Q_N];

endmodule

// File: tb/tb_sn7476.sv
// Directed table-driven bench for sn7476 plus hand-written multi-cycle sequences.
module tb_sn7476;

  logic clk = 1'b0;
  logic rst;
  logic p1, p2, p3, p4, p5, p6, p7, p8, p9, p12, p13, p16;
  logic p10, p11, p14, p15;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sn7476 dut (
    .clk (clk), .rst (rst),
    .p1  (p1),  .p2  (p2),  .p3  (p3),  .p4  (p4),
    .p5  (p5),  .p6  (p6),  .p7  (p7),  .p8  (p8),
    .p9  (p9),  .p10 (p10), .p11 (p11), .p12 (p12),
    .p13 (p13), .p14 (p14), .p15 (p15), .p16 (p16)
  );

  typedef struct {
    int   ff;       // 1 or 2
    logic pre_n;
    logic clr_n;
    logic j;
    logic k;
    logic pulse;    // 1: run a full pin-clock pulse, 0: one clk tick
    logic q1, qn1, q2, qn2;
    string name;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    p1 = 0; p2 = 1; p3 = 1; p4 = 0; p16 = 0;
    p6 = 0; p7 = 1; p8 = 1; p9 = 0; p12 = 0;
  endtask

  task automatic set_ff(input int ff, input logic pre_n, input logic clr_n,
                        input logic j, input logic k);
    if (ff == 1) begin
      p2 = pre_n; p3 = clr_n; p4 = j; p16 = k;
    end else begin
      p7 = pre_n; p8 = clr_n; p9 = j; p12 = k;
    end
  endtask

  task automatic set_pin_clk(input int ff, input logic v);
    if (ff == 1) p1 = v;
    else         p6 = v;
  endtask

  task automatic check_all(input string name, input logic q1, input logic qn1,
                           input logic q2, input logic qn2);
    check({name, ".p15"}, p15, q1);
    check({name, ".p14"}, p14, qn1);
    check({name, ".p11"}, p11, q2);
    check({name, ".p10"}, p10, qn2);
    $display("vec %-10s p15=%b p14=%b p11=%b p10=%b", name, p15, p14, p11, p10);
  endtask

  initial begin
    //          ff pre clr j  k  pul q1 qn1 q2 qn2
    vecs[0]  = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 1, "pre1"};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 1, "clr1"};
    vecs[2]  = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, "rel1"};
    vecs[3]  = '{2, 0, 1, 0, 0, 0, 0, 1, 1, 0, "pre2"};
    vecs[4]  = '{2, 1, 0, 0, 0, 0, 0, 1, 0, 1, "clr2"};
    vecs[5]  = '{2, 1, 1, 0, 0, 0, 0, 1, 0, 1, "rel2"};
    vecs[6]  = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 1, "jk1_01"};
    vecs[7]  = '{1, 1, 1, 1, 0, 1, 1, 0, 0, 1, "jk1_10"};
    vecs[8]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1, "jk1_00"};
    vecs[9]  = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1, "jk1_11a"};
    vecs[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, "jk1_11b"};
    vecs[11] = '{2, 1, 1, 0, 1, 1, 1, 0, 0, 1, "jk2_01"};
    vecs[12] = '{2, 1, 1, 1, 0, 1, 1, 0, 1, 0, "jk2_10"};
    vecs[13] = '{2, 1, 1, 0, 0, 1, 1, 0, 1, 0, "jk2_00"};
    vecs[14] = '{2, 1, 1, 1, 1, 1, 1, 0, 0, 1, "jk2_11a"};
    vecs[15] = '{2, 1, 1, 1, 1, 1, 1, 0, 1, 0, "jk2_11b"};
    vecs[16] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, "both_low"};
    vecs[17] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 0, "both_rel"};

    rst = 1; p5 = 1; p13 = 0;
    idle_pins();
    #1;
    check_all("reset", 0, 1, 0, 1);
    tick(2);
    rst = 0;
    tick(2);
    check_all("post_rst", 0, 1, 0, 1);

    for (int i = 0; i < 18; i++) begin
      idle_pins();
      set_ff(vecs[i].ff, vecs[i].pre_n, vecs[i].clr_n, vecs[i].j, vecs[i].k);
      if (vecs[i].pulse) begin
        set_pin_clk(vecs[i].ff, 1'b1);
        tick(2);
        set_pin_clk(vecs[i].ff, 1'b0);
        tick(2);
      end else begin
        tick(1);
      end
      check_all(vecs[i].name, vecs[i].q1, vecs[i].qn1, vecs[i].q2, vecs[i].qn2);
    end

    // Rising pin clock leaves Q alone; Q moves one clk after the fall is sampled.
    idle_pins();
    p4 = 1; p1 = 1;
    tick(2);
    check("rise_no_change", p15, 1'b0);
    p1 = 0;
    #1;
    check("before_fall_edge", p15, 1'b0);
    tick(1);
    check("after_fall_edge", p15, 1'b1);
    $display("seq edge_timing p15=%b", p15);

    // K pulse while pin clock high: caught by ones-catching master only.
    idle_pins();
    p1 = 1;
    tick(2);
    p16 = 1;
    tick(1);
    p16 = 0;
    tick(1);
    p1 = 0;
    tick(2);
`ifdef SN7476_ONES_CATCH_EN
    check("ones_catch", p15, 1'b0);
`else
    check("ones_catch", p15, 1'b1);
`endif
    $display("seq ones_catch p15=%b", p15);

    // Reset in the middle of a pin-clock pulse with Q=1.
    idle_pins();
    p4 = 1; p1 = 1;
    tick(2);
    p1 = 0;
    tick(2);
    check("pre_rst_q", p15, 1'b1);
    p4 = 0; p1 = 1;
    tick(1);
    rst = 1;
    #1;
    check("rst_mid_q", p15, 1'b0);
    check("rst_mid_qn", p14, 1'b1);
    tick(1);
    rst = 0;
    tick(1);
    p1 = 0;
    tick(2);
    check("rst_after_fall_q", p15, 1'b0);
    check("rst_after_fall_qn", p14, 1'b1);
    $display("seq rst_mid p15=%b p14=%b", p15, p14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
